// File: rtl/axi_read_arbiter.sv
// Two-client AXI4 read arbiter: merges I-cache and D-cache burst reads onto one AR/R channel pair.
// One transaction in flight; data side preferred, with a streak limit that eventually forces an inst grant.
module axi_read_arbiter #(
    parameter logic [3:0] ID_INST         = 4'd0,
    parameter logic [3:0] ID_DATA         = 4'd1,
    parameter int         MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    localparam int NCLI     = 2;
    localparam int CLI_INST = 0;
    localparam int CLI_DATA = 1;
    localparam int SW       = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]      state_reg,  state_next;
    logic [NCLI-1:0] grant_reg,  grant_next;
    logic [SW-1:0]   streak_reg, streak_next;
    logic [3:0]      arid_reg,   arid_next;
    logic [31:0]     araddr_reg, araddr_next;
    logic [7:0]      arlen_reg,  arlen_next;
    logic [2:0]      arsize_reg, arsize_next;
    logic            rd_err_reg, rd_err_next;

    logic [NCLI-1:0] req_valid;
    logic [NCLI-1:0] beat_ready;
    logic [NCLI-1:0] win;
    logic [NCLI-1:0] client_arready;
    logic [NCLI-1:0] client_rvalid;
    logic            in_idle;
    logic            in_addr;
    logic            in_data;
    logic            force_inst;
    logic            beat_acc;

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_addr    = (state_reg == ST_ADDR);
    assign in_data    = (state_reg == ST_DATA);
    assign req_valid  = {d_arvalid, i_arvalid};
    assign beat_ready = {d_rready, i_rready};
    assign force_inst = (streak_reg == STREAK_MAX);

    // Data wins a tie unless it has already won MAX_DATA_STREAK times in a row over a waiting inst.
    assign win[CLI_INST] = i_arvalid && (!d_arvalid || force_inst);
    assign win[CLI_DATA] = d_arvalid && !win[CLI_INST];

    generate
        for (genvar gi = 0; gi < NCLI; gi++) begin : g_client
            assign client_arready[gi] = in_idle && win[gi];
            assign client_rvalid[gi]  = in_data && grant_reg[gi] && rvalid;
        end
    endgenerate

    assign rready   = in_data && |(grant_reg & beat_ready);
    assign beat_acc = in_data && rvalid && rready;

    assign i_arready = client_arready[CLI_INST];
    assign d_arready = client_arready[CLI_DATA];
    assign i_rvalid  = client_rvalid[CLI_INST];
    assign d_rvalid  = client_rvalid[CLI_DATA];
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;
    assign i_rlast   = rlast;
    assign d_rlast   = rlast;

    assign arid    = arid_reg;
    assign araddr  = araddr_reg;
    assign arlen   = arlen_reg;
    assign arsize  = arsize_reg;
    assign arburst = 2'b01;
    assign arvalid = in_addr;
    assign rd_err  = rd_err_reg;

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        streak_next = streak_reg;
        arid_next   = arid_reg;
        araddr_next = araddr_reg;
        arlen_next  = arlen_reg;
        arsize_next = arsize_reg;
        // A bad response or a stray RID is flagged, but the beat is still delivered.
        rd_err_next = beat_acc && ((rresp != 2'b00) || (rid != arid_reg));

        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_next = win;
                    state_next = ST_ADDR;
                    if (win[CLI_DATA]) begin
                        arid_next   = ID_DATA;
                        araddr_next = d_araddr;
                        arlen_next  = {4'b0000, d_arlen};
                        arsize_next = d_arsize;
                        if (!i_arvalid) begin
                            streak_next = '0;
                        end else if (!force_inst) begin
                            streak_next = streak_reg + 1'b1;
                        end
                    end else begin
                        arid_next   = ID_INST;
                        araddr_next = i_araddr;
                        arlen_next  = {4'b0000, i_arlen};
                        arsize_next = 3'b010;
                        streak_next = '0;
                    end
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_acc && rlast) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            streak_reg <= '0;
            arid_reg   <= '0;
            araddr_reg <= '0;
            arlen_reg  <= '0;
            arsize_reg <= '0;
            rd_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            streak_reg <= streak_next;
            arid_reg   <= arid_next;
            araddr_reg <= araddr_next;
            arlen_reg  <= arlen_next;
            arsize_reg <= arsize_next;
            rd_err_reg <= rd_err_next;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: each scenario task drives the ports and checks against hand-derived values.
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] i_araddr;
    logic [3:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready;
    logic [31:0] d_araddr;
    logic [3:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_err;

    int checks = 0;
    int errors = 0;

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
        .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Slave accepts the pending AR in one cycle.
    task automatic do_ar;
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // Slave returns n OKAY beats back to back (clients are left ready).
    task automatic feed_beats(input int n, input logic [3:0] id);
        for (int k = 0; k < n; k++) begin
            rvalid = 1'b1;
            rid    = id;
            rdata  = 32'hB000_0000 + 32'(k);
            rresp  = 2'b00;
            rlast  = (k == n - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rid    = 4'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rvalid = 1'b1;
        #1;
        checks++; if ({arvalid, arid, araddr, arlen, arsize} !== 48'd0) begin errors++; $display("FAIL reset_ar_regs got %h exp 0", {arvalid, arid, araddr, arlen, arsize}); end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b exp 0", rd_err); end
        checks++; if ({rready, i_rvalid, d_rvalid, i_arready, d_arready} !== 5'b0) begin errors++; $display("FAIL reset_handshakes got %b exp 00000", {rready, i_rvalid, d_rvalid, i_arready, d_arready}); end
        rvalid = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_inst_only;
        i_araddr = 32'h1FC0_0020; i_arlen = 4'd7; i_arvalid = 1'b1;
        #1;
        checks++; if ({i_arready, d_arready} !== 2'b10) begin errors++; $display("FAIL inst_arready got %b exp 10", {i_arready, d_arready}); end
        tick();
        i_arvalid = 1'b0;
        #1;
        checks++; if ({arvalid, arid, araddr, arlen, arsize, arburst} !== {1'b1, 4'd0, 32'h1FC0_0020, 8'd7, 3'd2, 2'd1}) begin errors++; $display("FAIL inst_ar_fields got %h exp %h", {arvalid, arid, araddr, arlen, arsize, arburst}, {1'b1, 4'd0, 32'h1FC0_0020, 8'd7, 3'd2, 2'd1}); end
        do_ar();
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1; rid = 4'd0; rresp = 2'b00; rlast = (k == 7);
            rdata = 32'hA000_0000 + 32'(k);
            #1;
            checks++; if ({i_rvalid, d_rvalid, rready, i_rlast} !== {3'b101, (k == 7)}) begin errors++; $display("FAIL inst_beat%0d_ctl got %b exp %b", k, {i_rvalid, d_rvalid, rready, i_rlast}, {3'b101, (k == 7)}); end
            checks++; if (i_rdata !== 32'hA000_0000 + 32'(k)) begin errors++; $display("FAIL inst_beat%0d_data got %h exp %h", k, i_rdata, 32'hA000_0000 + 32'(k)); end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        checks++; if ({arvalid, rd_err} !== 2'b00) begin errors++; $display("FAIL inst_done got %b exp 00", {arvalid, rd_err}); end
        $display("test_inst_only done");
    endtask

    task automatic test_simultaneous;
        i_araddr = 32'h0000_1000; i_arlen = 4'd3; i_arvalid = 1'b1;
        d_araddr = 32'h0000_2000; d_arlen = 4'd0; d_arsize = 3'd0; d_arvalid = 1'b1;
        #1;
        checks++; if ({d_arready, i_arready} !== 2'b10) begin errors++; $display("FAIL sim_grant got %b exp 10", {d_arready, i_arready}); end
        tick();
        d_arvalid = 1'b0;
        #1;
        checks++; if ({arid, araddr, arlen, arsize, i_arready} !== {4'd1, 32'h2000, 8'd0, 3'd0, 1'b0}) begin errors++; $display("FAIL sim_data_ar got %h exp %h", {arid, araddr, arlen, arsize, i_arready}, {4'd1, 32'h2000, 8'd0, 3'd0, 1'b0}); end
        do_ar();
        rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 32'h5555_AAAA;
        #1;
        checks++; if ({d_rvalid, i_rvalid, i_arready, d_rdata} !== {3'b100, 32'h5555_AAAA}) begin errors++; $display("FAIL sim_data_beat got %h exp %h", {d_rvalid, i_rvalid, i_arready, d_rdata}, {3'b100, 32'h5555_AAAA}); end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        checks++; if ({i_arready, arvalid} !== 2'b10) begin errors++; $display("FAIL sim_inst_after_idle got %b exp 10", {i_arready, arvalid}); end
        tick();
        i_arvalid = 1'b0;
        #1;
        checks++; if ({arid, araddr, arlen, arsize} !== {4'd0, 32'h1000, 8'd3, 3'd2}) begin errors++; $display("FAIL sim_inst_ar got %h exp %h", {arid, araddr, arlen, arsize}, {4'd0, 32'h1000, 8'd3, 3'd2}); end
        do_ar();
        feed_beats(4, 4'd0);
        $display("test_simultaneous done");
    endtask

    task automatic test_data_hogging;
        logic [5:0] exp_data;
        exp_data = 6'b101111;  // grant g is data when bit g set: 4 data, 1 inst, then data again
        i_araddr = 32'h0000_5000; i_arlen = 4'd0; i_arvalid = 1'b1;
        d_araddr = 32'h0000_6000; d_arlen = 4'd0; d_arsize = 3'd2; d_arvalid = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            checks++; if ({d_arready, i_arready} !== {exp_data[g], !exp_data[g]}) begin errors++; $display("FAIL hog_grant%0d got %b exp %b", g, {d_arready, i_arready}, {exp_data[g], !exp_data[g]}); end
            tick();
            #1;
            checks++; if (arid !== (exp_data[g] ? 4'd1 : 4'd0)) begin errors++; $display("FAIL hog_arid%0d got %0d exp %0d", g, arid, exp_data[g] ? 1 : 0); end
            do_ar();
            feed_beats(1, exp_data[g] ? 4'd1 : 4'd0);
        end
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        $display("test_data_hogging done");
    endtask

    task automatic test_slave_backpressure;
        i_araddr = 32'h0000_4000; i_arlen = 4'd1; i_arvalid = 1'b1;
        tick();
        i_arvalid = 1'b0;
        rvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({arvalid, araddr} !== {1'b1, 32'h4000}) begin errors++; $display("FAIL bp_ar_hold%0d got %h exp %h", c, {arvalid, araddr}, {1'b1, 32'h4000}); end
            checks++; if ({i_rvalid, rready} !== 2'b00) begin errors++; $display("FAIL bp_rvalid%0d got %b exp 00", c, {i_rvalid, rready}); end
            tick();
        end
        rvalid = 1'b0;
        do_ar();
        feed_beats(2, 4'd5);
        #1;
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL rid_mismatch_err got %b exp 1", rd_err); end
        tick();
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL rid_err_pulse got %b exp 0", rd_err); end
        $display("test_slave_backpressure done");
    endtask

    task automatic test_client_backpressure;
        int accepted;
        accepted = 0;
        i_araddr = 32'h0000_8000; i_arlen = 4'd3; i_arvalid = 1'b1;
        tick();
        i_arvalid = 1'b0;
        do_ar();
        rvalid = 1'b1; rid = 4'd0; rresp = 2'b00; rlast = 1'b0; rdata = 32'h0000_00C0; i_rready = 1'b1;
        #1;
        checks++; if ({i_rvalid, rready, i_rdata} !== {2'b11, 32'hC0}) begin errors++; $display("FAIL cbp_beat0 got %h exp %h", {i_rvalid, rready, i_rdata}, {2'b11, 32'hC0}); end
        if (rready === 1'b1) accepted++;
        tick();
        rdata = 32'h0000_00C1; i_rready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if ({i_rvalid, rready, i_rdata} !== {2'b10, 32'hC1}) begin errors++; $display("FAIL cbp_stall%0d got %h exp %h", c, {i_rvalid, rready, i_rdata}, {2'b10, 32'hC1}); end
            if (rready === 1'b1) accepted++;
            tick();
        end
        i_rready = 1'b1;
        #1;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL cbp_resume got %b exp 1", rready); end
        if (rready === 1'b1) accepted++;
        tick();
        rdata = 32'h0000_00C2; rresp = 2'b10;
        #1;
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL cbp_err_early got %b exp 0", rd_err); end
        if (rready === 1'b1) accepted++;
        tick();
        rdata = 32'h0000_00C3; rresp = 2'b00; rlast = 1'b1;
        #1;
        checks++; if ({rd_err, i_rlast, i_rvalid} !== 3'b111) begin errors++; $display("FAIL cbp_err_pulse got %b exp 111", {rd_err, i_rlast, i_rvalid}); end
        if (rready === 1'b1) accepted++;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        checks++; if ({rd_err, arvalid} !== 2'b00) begin errors++; $display("FAIL cbp_err_clear got %b exp 00", {rd_err, arvalid}); end
        checks++; if (accepted !== 4) begin errors++; $display("FAIL cbp_beat_count got %0d exp 4", accepted); end
        $display("test_client_backpressure done");
    endtask

    task automatic test_reset_mid;
        i_araddr = 32'h1FC0_0100; i_arlen = 4'd7; i_arvalid = 1'b1;
        tick();
        i_arvalid = 1'b0;
        do_ar();
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rid = 4'd0; rresp = 2'b00; rlast = 1'b0; rdata = 32'hD000_0000 + 32'(k);
            tick();
        end
        rst = 1'b1;
        tick();
        #1;
        checks++; if ({arvalid, arid, araddr, arlen, arsize} !== 48'd0) begin errors++; $display("FAIL rstmid_ar_regs got %h exp 0", {arvalid, arid, araddr, arlen, arsize}); end
        checks++; if ({rd_err, rready, i_rvalid, d_rvalid} !== 4'b0) begin errors++; $display("FAIL rstmid_outputs got %b exp 0000", {rd_err, rready, i_rvalid, d_rvalid}); end
        rst = 1'b0; rvalid = 1'b0;
        tick();
        d_araddr = 32'h0000_3000; d_arlen = 4'd1; d_arsize = 3'd2; d_arvalid = 1'b1;
        #1;
        checks++; if ({d_arready, i_arready} !== 2'b10) begin errors++; $display("FAIL rstmid_fresh_grant got %b exp 10", {d_arready, i_arready}); end
        tick();
        d_arvalid = 1'b0;
        #1;
        checks++; if ({arid, araddr, arlen, arsize} !== {4'd1, 32'h3000, 8'd1, 3'd2}) begin errors++; $display("FAIL rstmid_fresh_ar got %h exp %h", {arid, araddr, arlen, arsize}, {4'd1, 32'h3000, 8'd1, 3'd2}); end
        do_ar();
        feed_beats(2, 4'd1);
        #1;
        checks++; if ({rd_err, arvalid, rready} !== 3'b000) begin errors++; $display("FAIL rstmid_fresh_done got %b exp 000", {rd_err, arvalid, rready}); end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1;
        i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b1;
        d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b1;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        test_reset();
        test_inst_only();
        test_simultaneous();
        test_data_hogging();
        test_slave_backpressure();
        test_client_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
